mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 256x8 program/data memory between two requesters: the processor core (CPU port) and an external host loader (HOST port).
- Replaces the direct ext_write path into memory. The host can load programs while the CPU runs, instead of both writing on the same edge with undefined ordering.
- Uses registered round-robin arbitration, a host burst lock and a starvation timer.
- Sits between the controller/datapath, the host interface and the memory unit.

Parameters:
- word_size, 8, data and address width
- MAX_WAIT, 8, cycles a waiting requester tolerates before it preempts an unlocked owner (range 1..15)
- WAIT_W, 4, width of the wait counters

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-low
- cpu_req  input  1  CPU access request
- cpu_we  input  1  CPU write enable (0 = read)
- cpu_addr  input  word_size  CPU address
- cpu_wdata  input  word_size  CPU write data
- cpu_gnt  output  1  CPU owns the memory port this cycle (registered)
- cpu_rvalid  output  1  rdata holds the CPU read result (one-cycle pulse)
- host_req  input  1  host access request
- host_we  input  1  host write enable
- host_addr  input  word_size  host address
- host_wdata  input  word_size  host write data
- host_lock  input  1  host burst lock; the host keeps its grant while this and host_req are high
- host_gnt  output  1  host owns the memory port (registered)
- host_rvalid  output  1  rdata holds the host read result
- rdata  output  word_size  registered read data
- mem_addr  output  word_size  memory address
- mem_wdata  output  word_size  memory write data
- mem_we  output  1  memory write strobe
- mem_rdata  input  word_size  combinational memory read data

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-low. It is sampled only on the rising edge of clk.
- Reset values:
  - owner = IDLE, last = HOST (so the CPU wins the first tie).
  - cpu_gnt = host_gnt = 0; cpu_rvalid = host_rvalid = 0; rdata = 0.
  - Both wait counters = 0.
  - Reset mid-access aborts the access with no write and no rvalid.
- States: IDLE, CPU, HOST. cpu_gnt = (owner==CPU), host_gnt = (owner==HOST), both registered; the two grants are never high together.
- Memory port (combinational from owner):
  - Drives the owner's addr and wdata; mem_we = owner_req & owner_we.
  - In IDLE: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Access rule: an access occurs in each cycle where gnt=1 and req=1.
  - Write commits at that clock edge.
  - Read: mem_rdata is captured into rdata at that edge, and the matching rvalid is high the following cycle only.
  - A granted requester with req low performs no access.
  - Back-to-back accesses give one access per cycle.
- Latency: req rises in IDLE -> gnt high on the next cycle (1-cycle grant latency). Read data arrives one cycle after the access cycle.
- Transitions, evaluated each edge, first match wins:
  1. IDLE: both req -> the one not equal to last; single req -> that one; none -> IDLE.
  2. Owner req low -> other if its req is high, else IDLE.
  3. The other requester's wait counter == MAX_WAIT and the owner is not locked -> switch to the other (preemption). The CPU is never locked; the HOST is locked when host_lock=1.
  4. Otherwise owner is unchanged.
- last updates to the new owner on every grant change into CPU or HOST.
- Wait counters: increment while req=1 and gnt=0, saturate at MAX_WAIT. Clear when gnt=1 or req=0.
- A preempted owner must keep req high and re-arbitrate. Its in-flight access in the preemption cycle completes normally, since preemption only takes effect from the next cycle.
- Address and data widths are passed through unmodified; no arithmetic on addresses.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds outputs cpu_acc_cnt[15:0], host_acc_cnt[15:0] and preempt_cnt[7:0].
  - The access counters increment on each completed access for that requester.
  - preempt_cnt increments on each preemption.
  - All counters wrap at their maximum, reset to 0, and are cleared when rst=0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then single CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x10, memory[0x10]=0xA5 -> cpu_gnt is 1 the next cycle; in the following cycle cpu_rvalid=1 and rdata=0xA5; host_gnt stays 0.
- Simultaneous requests from reset: both req=1 -> CPU granted first. Then cpu_req drops -> host_gnt=1 the next cycle. Both re-request from IDLE -> CPU is granted (last=HOST).
- Host burst write: host_lock=1 and host_req=1, writing 0x01..0x20 to addrs 0x00..0x1F, with CPU requesting throughout -> 32 consecutive writes, no preemption. cpu_gnt=1 one cycle after host_req drops; readback matches.
- Preemption: host owns unlocked, CPU requests continuously -> after 8 waiting cycles, host_gnt=0 and cpu_gnt=1 on the next cycle. The host access in the preemption cycle still commits.
- Mid-access reset: host write granted and rst=0 asserted on the same edge -> memory unchanged, all grants, rvalids and rdata read 0 the next cycle.
- MEM_ARB_STATS_EN: 5 CPU reads plus 3 host writes plus 1 preemption -> cpu_acc_cnt=5, host_acc_cnt=3, preempt_cnt=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin CPU/host arbiter for a single-port 256x8 memory.
// Optional access/preemption statistics are enabled with `define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int word_size = 8,
    parameter int MAX_WAIT  = 8,
    parameter int WAIT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [word_size-1:0] cpu_addr,
    input  logic [word_size-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [word_size-1:0] host_addr,
    input  logic [word_size-1:0] host_wdata,
    input  logic                 host_lock,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [word_size-1:0] rdata,
    output logic [word_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [word_size-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]          cpu_acc_cnt,
    output logic [15:0]          host_acc_cnt,
    output logic [7:0]           preempt_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, CPU, HOST} owner_t;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    owner_t owner_q, owner_d, last_q, last_d;
    logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d, host_wait_q, host_wait_d;
    logic [word_size-1:0] rdata_q, rdata_d;
    logic cpu_rvalid_q, cpu_rvalid_d, host_rvalid_q, host_rvalid_d;
    logic cpu_acc, host_acc, preempt;

    assign cpu_gnt     = (owner_q == CPU);
    assign host_gnt    = (owner_q == HOST);
    assign cpu_acc     = cpu_gnt & cpu_req;
    assign host_acc    = host_gnt & host_req;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign rdata       = rdata_q;

    // Memory port follows the owner; a reset on this edge suppresses the write so it aborts cleanly.
    always_comb begin
        mem_addr  = cpu_gnt ? cpu_addr : (host_gnt ? host_addr : '0);
        mem_wdata = cpu_gnt ? cpu_wdata : (host_gnt ? host_wdata : '0);
        mem_we    = rst & ((cpu_acc & cpu_we) | (host_acc & host_we));
    end

    // Next owner: IDLE tie-break by last, release on req drop, preempt an unlocked owner after a full wait.
    always_comb begin
        owner_d = owner_q;
        preempt = 1'b0;
        case (owner_q)
            IDLE: owner_d = (cpu_req && host_req) ? ((last_q == HOST) ? CPU : HOST) :
                            cpu_req ? CPU : (host_req ? HOST : IDLE);
            CPU: begin
                if (!cpu_req) begin
                    owner_d = host_req ? HOST : IDLE;
                end else if (host_wait_q == WAIT_MAX) begin
                    owner_d = HOST;
                    preempt = 1'b1;
                end
            end
            HOST: begin
                if (!host_req) begin
                    owner_d = cpu_req ? CPU : IDLE;
                end else if (cpu_wait_q == WAIT_MAX && !host_lock) begin
                    owner_d = CPU;
                    preempt = 1'b1;
                end
            end
            default: owner_d = IDLE;
        endcase
        last_d = (owner_d != owner_q && owner_d != IDLE) ? owner_d : last_q;
    end

    // Saturating wait counters and read-data capture for the access happening this cycle.
    always_comb begin
        cpu_wait_d    = (cpu_req && !cpu_gnt) ?
                        ((cpu_wait_q == WAIT_MAX) ? cpu_wait_q : cpu_wait_q + 1'b1) : '0;
        host_wait_d   = (host_req && !host_gnt) ?
                        ((host_wait_q == WAIT_MAX) ? host_wait_q : host_wait_q + 1'b1) : '0;
        cpu_rvalid_d  = cpu_acc & ~cpu_we;
        host_rvalid_d = host_acc & ~host_we;
        rdata_d       = (cpu_rvalid_d | host_rvalid_d) ? mem_rdata : rdata_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q       <= IDLE;
            last_q        <= HOST;
            cpu_wait_q    <= '0;
            host_wait_q   <= '0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            owner_q       <= owner_d;
            last_q        <= last_d;
            cpu_wait_q    <= cpu_wait_d;
            host_wait_q   <= host_wait_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cpu_acc_cnt_q, host_acc_cnt_q;
    logic [7:0]  preempt_cnt_q;

    assign cpu_acc_cnt  = cpu_acc_cnt_q;
    assign host_acc_cnt = host_acc_cnt_q;
    assign preempt_cnt  = preempt_cnt_q;

    // Wrapping statistics counters for completed accesses and preemptions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_acc_cnt_q  <= '0;
            host_acc_cnt_q <= '0;
            preempt_cnt_q  <= '0;
        end else begin
            cpu_acc_cnt_q  <= cpu_acc_cnt_q + 16'(cpu_acc);
            host_acc_cnt_q <= host_acc_cnt_q + 16'(host_acc);
            preempt_cnt_q  <= preempt_cnt_q + 8'(preempt);
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random traffic against a reference model.
module tb_mem_port_arbiter;
    localparam int MAXW = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
    logic cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] cpu_acc_cnt, host_acc_cnt;
    logic [7:0] preempt_cnt;
`endif
    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    int checks = 0;
    int errors = 0;
    int m_owner = 0, m_last = 1, m_rdata = 0, m_pre = 0;
    int m_wait [2] = '{0, 0};
    int m_rv [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .cpu_acc_cnt(cpu_acc_cnt), .host_acc_cnt(host_acc_cnt), .preempt_cnt(preempt_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the reference model from the current inputs, clock the DUT, compare.
    task automatic cyc();
        int req [2], we [2], ad [2], wd [2], acc [2];
        int nown, o, x;
        req = '{int'(cpu_req), int'(host_req)};
        we  = '{int'(cpu_we), int'(host_we)};
        ad  = '{int'(cpu_addr), int'(host_addr)};
        wd  = '{int'(cpu_wdata), int'(host_wdata)};
        if (!rst) begin
            m_owner = 0; m_last = 1; m_rdata = 0; m_pre = 0;
            m_wait = '{0, 0}; m_rv = '{0, 0}; m_cnt = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                acc[i] = (m_owner == i + 1 && req[i] != 0) ? 1 : 0;
                m_rv[i] = (acc[i] != 0 && we[i] == 0) ? 1 : 0;
                if (m_rv[i] != 0) m_rdata = int'(shadow[ad[i]]);
                if (acc[i] != 0 && we[i] != 0) shadow[ad[i]] = 8'(wd[i]);
                m_cnt[i] = (m_cnt[i] + acc[i]) % 65536;
            end
            if (m_owner == 0) begin
                nown = (req[0] != 0 && req[1] != 0) ? 2 - m_last : (req[0] != 0 ? 1 : (req[1] != 0 ? 2 : 0));
            end else begin
                o = m_owner - 1;
                x = 1 - o;
                nown = m_owner;
                if (req[o] == 0) nown = (req[x] != 0) ? x + 1 : 0;
                else if (m_wait[x] == MAXW && !(o == 1 && host_lock)) begin
                    nown = x + 1;
                    m_pre = (m_pre + 1) % 256;
                end
            end
            for (int i = 0; i < 2; i++)
                m_wait[i] = (req[i] != 0 && m_owner != i + 1) ? ((m_wait[i] < MAXW) ? m_wait[i] + 1 : MAXW) : 0;
            if (nown != m_owner && nown != 0) m_last = nown - 1;
            m_owner = nown;
        end
        @(posedge clk);
        #1;
        chk("model_cpu_gnt", int'(cpu_gnt), (m_owner == 1) ? 1 : 0);
        chk("model_host_gnt", int'(host_gnt), (m_owner == 2) ? 1 : 0);
        chk("model_cpu_rvalid", int'(cpu_rvalid), m_rv[0]);
        chk("model_host_rvalid", int'(host_rvalid), m_rv[1]);
        chk("model_rdata", int'(rdata), m_rdata);
`ifdef MEM_ARB_STATS_EN
        chk("model_cpu_acc_cnt", int'(cpu_acc_cnt), m_cnt[0]);
        chk("model_host_acc_cnt", int'(host_acc_cnt), m_cnt[1]);
        chk("model_preempt_cnt", int'(preempt_cnt), m_pre);
`endif
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    endtask

    typedef struct {
        logic r, cr, cw;
        logic [7:0] ca;
        logic hr, hw;
        logic [7:0] ha;
        logic hl, ecg, ehg, ecv, ehv;
        logic [7:0] erd;
    } vec_t;
    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] <= 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        mem[8'h10] <= 8'hA5; shadow[8'h10] = 8'hA5;
        mem[8'h11] <= 8'h3C; shadow[8'h11] = 8'h3C;
        mem[8'h50] <= 8'h12; shadow[8'h50] = 8'h12;
        mem[8'h60] <= 8'h5C; shadow[8'h60] = 8'h5C;
        #1;
        //            r cr cw ca     hr hw ha     hl cg hg cv hv rdata
        tbl[0]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 1, 0, 8'h10, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00};
        tbl[2]  = '{1, 1, 0, 8'h10, 0, 0, 8'h00, 0, 1, 0, 1, 0, 8'hA5};
        tbl[3]  = '{1, 0, 0, 8'h10, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hA5};
        tbl[4]  = '{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        tbl[5]  = '{1, 1, 0, 8'h10, 1, 0, 8'h11, 0, 1, 0, 0, 0, 8'h00};
        tbl[6]  = '{1, 1, 0, 8'h10, 1, 0, 8'h11, 0, 1, 0, 1, 0, 8'hA5};
        tbl[7]  = '{1, 0, 0, 8'h10, 1, 0, 8'h11, 0, 0, 1, 0, 0, 8'hA5};
        tbl[8]  = '{1, 0, 0, 8'h10, 1, 0, 8'h11, 0, 0, 1, 0, 1, 8'h3C};
        tbl[9]  = '{1, 0, 0, 8'h10, 0, 0, 8'h11, 0, 0, 0, 0, 0, 8'h3C};
        tbl[10] = '{1, 1, 0, 8'h10, 1, 0, 8'h11, 0, 1, 0, 0, 0, 8'h3C};
        tbl[11] = '{1, 0, 0, 8'h10, 0, 0, 8'h11, 0, 0, 0, 0, 0, 8'h3C};
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].r; cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca;
            host_req = tbl[i].hr; host_we = tbl[i].hw; host_addr = tbl[i].ha; host_lock = tbl[i].hl;
            cyc();
            chk($sformatf("vec%0d_cpu_gnt", i), int'(cpu_gnt), int'(tbl[i].ecg));
            chk($sformatf("vec%0d_host_gnt", i), int'(host_gnt), int'(tbl[i].ehg));
            chk($sformatf("vec%0d_cpu_rvalid", i), int'(cpu_rvalid), int'(tbl[i].ecv));
            chk($sformatf("vec%0d_host_rvalid", i), int'(host_rvalid), int'(tbl[i].ehv));
            chk($sformatf("vec%0d_rdata", i), int'(rdata), int'(tbl[i].erd));
        end

        // Locked host burst of 32 writes while the CPU keeps requesting.
        idle_inputs(); rst = 0; cyc(); rst = 1;
        host_req = 1; host_we = 1; host_lock = 1; host_addr = 0; host_wdata = 1;
        cyc();
        chk("burst_start_host_gnt", int'(host_gnt), 1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 0;
        for (int i = 0; i < 32; i++) begin
            host_addr = 8'(i); host_wdata = 8'(i + 1);
            cyc();
            chk("burst_host_gnt", int'(host_gnt), 1);
            chk("burst_cpu_gnt", int'(cpu_gnt), 0);
        end
        host_req = 0; host_lock = 0;
        cyc();
        chk("burst_end_cpu_gnt", int'(cpu_gnt), 1);
        chk("burst_end_host_gnt", int'(host_gnt), 0);
        for (int i = 0; i < 32; i++) chk($sformatf("burst_mem%0d", i), int'(mem[i]), i + 1);

        // Unlocked host is preempted by a CPU that has waited MAX_WAIT cycles.
        idle_inputs(); rst = 0; cyc(); rst = 1;
        host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 8'h80;
        cyc();
        chk("pre_start_host_gnt", int'(host_gnt), 1);
        cpu_req = 1;
        for (int k = 0; k < 9; k++) begin
            host_addr = 8'(8'h40 + k); host_wdata = 8'(8'h80 + k);
            cyc();
            if (k < 8) chk("pre_hold_host_gnt", int'(host_gnt), 1);
        end
        chk("pre_cpu_gnt", int'(cpu_gnt), 1);
        chk("pre_host_gnt", int'(host_gnt), 0);
        chk("pre_last_write", int'(mem[8'h48]), 8'h88);
`ifdef MEM_ARB_STATS_EN
        chk("pre_stat_preempt", int'(preempt_cnt), 1);
        chk("pre_stat_host_acc", int'(host_acc_cnt), 9);
        chk("pre_stat_cpu_acc", int'(cpu_acc_cnt), 0);
`endif

        // Reset asserted on the edge of a granted host write.
        idle_inputs(); rst = 0; cyc(); rst = 1;
        host_req = 1; host_we = 0; host_addr = 8'h60;
        cyc();
        chk("mrst_host_gnt", int'(host_gnt), 1);
        cyc();
        chk("mrst_read_rvalid", int'(host_rvalid), 1);
        chk("mrst_read_rdata", int'(rdata), 8'h5C);
        host_we = 1; host_addr = 8'h50; host_wdata = 8'hEE; rst = 0;
        cyc();
        chk("mrst_mem", int'(mem[8'h50]), 8'h12);
        chk("mrst_host_gnt0", int'(host_gnt), 0);
        chk("mrst_cpu_gnt0", int'(cpu_gnt), 0);
        chk("mrst_host_rvalid0", int'(host_rvalid), 0);
        chk("mrst_cpu_rvalid0", int'(cpu_rvalid), 0);
        chk("mrst_rdata0", int'(rdata), 0);

        // Random traffic, checked every cycle against the model.
        idle_inputs(); rst = 1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 149) != 0);
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_we = $urandom_range(0, 1);
            cpu_addr = 8'($urandom_range(0, 31));
            cpu_wdata = 8'($urandom);
            host_req = ($urandom_range(0, 3) != 0);
            host_we = $urandom_range(0, 1);
            host_addr = 8'($urandom_range(0, 31));
            host_wdata = 8'($urandom);
            host_lock = ($urandom_range(0, 4) == 0);
            cyc();
        end
        begin
            int bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) bad++;
            chk("final_mem_image", bad, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
